// File: rtl/fp_unpack128_nrm.sv
// binary128 unpacker: expands a packed operand into sign, 17-bit signed biased exponent,
// explicit-leading-bit significand and class flags; denormals are normalized over several cycles.
module fp_unpack128_nrm #(
   parameter int SHIFT_STEP = 16
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic           ce,
   input  logic           i_valid,
   output logic           i_ready,
   input  logic [127:0]   a,
   output logic           o_valid,
   input  logic           o_ready,
   output logic           o_sign,
   output logic [16:0]    o_exp,
   output logic [112:0]   o_sig,
   output logic           o_zero,
   output logic           o_inf,
   output logic           o_nan,
   output logic           o_snan,
   output logic           o_qnan,
   output logic           o_dn
);

   localparam int LZW = $clog2(SHIFT_STEP + 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      NORM = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t         state_q, state_d;
   logic           sign_q, sign_d;
   logic [16:0]    exp_q, exp_d;
   logic [112:0]   sig_q, sig_d;
   logic           zero_q, zero_d;
   logic           inf_q, inf_d;
   logic           nan_q, nan_d;
   logic           snan_q, snan_d;
   logic           qnan_q, qnan_d;
   logic           dn_q, dn_d;

   // operand classification and load values
   logic [14:0]    a_exp;
   logic [111:0]   a_frac;
   logic           a_exp_zero, a_exp_max, a_frac_zero;
   logic [16:0]    ld_exp;
   logic [112:0]   ld_sig;
   logic           ld_zero, ld_inf, ld_nan, ld_snan, ld_qnan, ld_dn;

   always_comb begin
      a_exp       = a[126:112];
      a_frac      = a[111:0];
      a_exp_zero  = ~|a_exp;
      a_exp_max   = &a_exp;
      a_frac_zero = ~|a_frac;
      ld_exp      = '0;
      ld_sig      = '0;
      ld_zero     = 1'b0;
      ld_inf      = 1'b0;
      ld_nan      = 1'b0;
      ld_snan     = 1'b0;
      ld_qnan     = 1'b0;
      ld_dn       = 1'b0;
      if (a_exp_max) begin
         ld_exp  = 17'h07FFF;
         ld_sig  = {1'b1, a_frac};
         ld_inf  = a_frac_zero;
         ld_nan  = ~a_frac_zero;
         ld_qnan = ~a_frac_zero & a_frac[111];
         ld_snan = ~a_frac_zero & ~a_frac[111];
      end else if (a_exp_zero) begin
         if (a_frac_zero) begin
            ld_zero = 1'b1;
         end else begin
            // denormals share the minimum normal exponent; NORM then rebases it
            ld_dn  = 1'b1;
            ld_exp = 17'd1;
            ld_sig = {1'b0, a_frac};
         end
      end else begin
         ld_exp = {2'b00, a_exp};
         ld_sig = {1'b1, a_frac};
      end
   end

   // leading-zero count over the top SHIFT_STEP bits of the significand
   logic [SHIFT_STEP-1:0] win;
   logic                  win_zero;
   logic [LZW-1:0]        lz;

   always_comb begin
      win      = sig_q[112 -: SHIFT_STEP];
      win_zero = ~|win;
      lz       = LZW'(SHIFT_STEP);
      for (int i = 0; i < SHIFT_STEP; i++) begin
         if (win[i]) begin
            lz = LZW'(SHIFT_STEP - 1 - i);
         end
      end
   end

   logic do_load;

   always_comb begin
      state_d = state_q;
      sign_d  = sign_q;
      exp_d   = exp_q;
      sig_d   = sig_q;
      zero_d  = zero_q;
      inf_d   = inf_q;
      nan_d   = nan_q;
      snan_d  = snan_q;
      qnan_d  = qnan_q;
      dn_d    = dn_q;
      do_load = 1'b0;

      if (ce) begin
         case (state_q)
            IDLE: begin
               if (i_valid) begin
                  do_load = 1'b1;
               end
            end
            NORM: begin
               if (win_zero) begin
                  sig_d = sig_q << SHIFT_STEP;
                  exp_d = exp_q - 17'(SHIFT_STEP);
               end else begin
                  sig_d   = sig_q << lz;
                  exp_d   = exp_q - 17'(lz);
                  state_d = DONE;
               end
            end
            DONE: begin
               if (o_ready) begin
                  if (i_valid) begin
                     do_load = 1'b1;
                  end else begin
                     state_d = IDLE;
                  end
               end
            end
            default: state_d = IDLE;
         endcase
      end

      if (do_load) begin
         sign_d  = a[127];
         exp_d   = ld_exp;
         sig_d   = ld_sig;
         zero_d  = ld_zero;
         inf_d   = ld_inf;
         nan_d   = ld_nan;
         snan_d  = ld_snan;
         qnan_d  = ld_qnan;
         dn_d    = ld_dn;
         state_d = ld_dn ? NORM : DONE;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         sign_q  <= 1'b0;
         exp_q   <= '0;
         sig_q   <= '0;
         zero_q  <= 1'b0;
         inf_q   <= 1'b0;
         nan_q   <= 1'b0;
         snan_q  <= 1'b0;
         qnan_q  <= 1'b0;
         dn_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         sign_q  <= sign_d;
         exp_q   <= exp_d;
         sig_q   <= sig_d;
         zero_q  <= zero_d;
         inf_q   <= inf_d;
         nan_q   <= nan_d;
         snan_q  <= snan_d;
         qnan_q  <= qnan_d;
         dn_q    <= dn_d;
      end
   end

   // a held result can be replaced in the same cycle it is taken, so streams have no bubble
   assign i_ready = (state_q == IDLE) | ((state_q == DONE) & o_ready);
   assign o_valid = (state_q == DONE);
   assign o_sign  = sign_q;
   assign o_exp   = exp_q;
   assign o_sig   = sig_q;
   assign o_zero  = zero_q;
   assign o_inf   = inf_q;
   assign o_nan   = nan_q;
   assign o_snan  = snan_q;
   assign o_qnan  = qnan_q;
   assign o_dn    = dn_q;

endmodule
